// File: rtl/dkong_input_ctrl.sv
// dkong_input_ctrl
//   Turns PS/2 key events and the merged MiSTer joystick word into the
//   active-low cabinet inputs of the Donkey Kong core. Directions can be
//   remapped for horizontal orientation. A start press is expanded into a
//   timed coin pulse, an idle gap and then a start pulse.
//
// Ports
//   clk_sys  in   core clock (24.576 MHz)
//   reset_n  in   asynchronous active-low reset
//   ps2_key  in   [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = E0)
//   joy      in   [0]R [1]L [2]D [3]U [4]jump [5]start1 [6]start2
//   rotate   in   1 = horizontal orientation, remap directions
//   o_u_n, o_d_n, o_l_n, o_r_n  out  directions, active-low
//   o_j_n                       out  jump, active-low
//   o_s1_n, o_s2_n              out  start 1P / 2P, active-low
//   o_c1_n                      out  coin, active-low
module dkong_input_ctrl #(
  parameter int CNT_W        = 24,
  parameter int COIN_CYCLES  = 2457600,
  parameter int GAP_CYCLES   = 4915200,
  parameter int START_CYCLES = 2457600
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        rotate,
  output logic        o_u_n,
  output logic        o_d_n,
  output logic        o_l_n,
  output logic        o_r_n,
  output logic        o_j_n,
  output logic        o_s1_n,
  output logic        o_s2_n,
  output logic        o_c1_n
);

  // Timer reload values: each phase counts N-1 down to 0, i.e. N cycles.
  localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START,
    S_WAIT_REL
  } state_t;

  // Joystick bits above start2 carry nothing for this core.
  logic unused_joy_bits;
  assign unused_joy_bits = ^joy[15:7];

  // ---------------------------------------------------------------------
  // PS/2 key tracking
  // ---------------------------------------------------------------------
  logic ps2_tog_q;
  logic ps2_evt;
  logic ps2_pressed;
  logic ps2_ext;
  logic [7:0] ps2_code;

  logic key_up, key_dn, key_lt, key_rt;
  logic key_sp, key_ct, key_s1, key_s2;

  assign ps2_evt     = ps2_key[10] ^ ps2_tog_q;
  assign ps2_pressed = ps2_key[9];
  assign ps2_ext     = ps2_key[8];
  assign ps2_code    = ps2_key[7:0];

  // Arrow keys match with or without the E0 prefix (numpad arrows too);
  // space, ctrl and F1/F2 only match their plain codes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_tog_q <= 1'b0;
      key_up    <= 1'b0;
      key_dn    <= 1'b0;
      key_lt    <= 1'b0;
      key_rt    <= 1'b0;
      key_sp    <= 1'b0;
      key_ct    <= 1'b0;
      key_s1    <= 1'b0;
      key_s2    <= 1'b0;
    end else begin
      ps2_tog_q <= ps2_key[10];
      if (ps2_evt) begin
        case (ps2_code)
          8'h75: key_up <= ps2_pressed;
          8'h72: key_dn <= ps2_pressed;
          8'h6B: key_lt <= ps2_pressed;
          8'h74: key_rt <= ps2_pressed;
          8'h29: if (!ps2_ext) key_sp <= ps2_pressed;
          8'h14: if (!ps2_ext) key_ct <= ps2_pressed;
          8'h05: if (!ps2_ext) key_s1 <= ps2_pressed;
          8'h06: if (!ps2_ext) key_s2 <= ps2_pressed;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directions and jump
  // ---------------------------------------------------------------------
  logic dir_u, dir_d, dir_l, dir_r, jump;

  assign dir_u = key_up | joy[3];
  assign dir_d = key_dn | joy[2];
  assign dir_l = key_lt | joy[1];
  assign dir_r = key_rt | joy[0];
  assign jump  = key_sp | key_ct | joy[4];

  // Horizontal orientation rotates the stick a quarter turn.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      o_u_n <= 1'b1;
      o_d_n <= 1'b1;
      o_l_n <= 1'b1;
      o_r_n <= 1'b1;
      o_j_n <= 1'b1;
    end else begin
      o_u_n <= ~(rotate ? dir_l : dir_u);
      o_d_n <= ~(rotate ? dir_r : dir_d);
      o_l_n <= ~(rotate ? dir_d : dir_l);
      o_r_n <= ~(rotate ? dir_u : dir_r);
      o_j_n <= ~jump;
    end
  end

  // ---------------------------------------------------------------------
  // Coin/start sequencer
  // ---------------------------------------------------------------------
  logic rq1, rq2, rq1_q, rq2_q;
  logic edge_arm;
  logic rise1, rise2;

  assign rq1 = key_s1 | joy[5];
  assign rq2 = key_s2 | joy[6];

  // edge_arm stays low for the first clock after reset so that a request
  // already held at release is only sampled, never seen as a fresh press.
  assign rise1 = edge_arm & rq1 & ~rq1_q;
  assign rise2 = edge_arm & rq2 & ~rq2_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rq1_q    <= 1'b0;
      rq2_q    <= 1'b0;
      edge_arm <= 1'b0;
    end else begin
      rq1_q    <= rq1;
      rq2_q    <= rq2;
      edge_arm <= 1'b1;
    end
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] timer, timer_d;
  logic             sel_2p, sel_2p_d;
  logic             c1_d, s1_d, s2_d;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      timer  <= '0;
      sel_2p <= 1'b0;
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      sel_2p <= sel_2p_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    sel_2p_d = sel_2p;
    case (state)
      S_IDLE: begin
        if (rise1 | rise2) begin
          sel_2p_d = rise2 & ~rise1;
          timer_d  = COIN_LOAD;
          state_d  = S_COIN;
        end
      end
      S_COIN: begin
        if (timer == '0) begin
          timer_d = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          timer_d = timer - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (timer == '0) begin
          timer_d = START_LOAD;
          state_d = S_START;
        end else begin
          timer_d = timer - CNT_W'(1);
        end
      end
      S_START: begin
        if (timer == '0) begin
          state_d = S_WAIT_REL;
        end else begin
          timer_d = timer - CNT_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (!rq1 && !rq2) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode works on the next state so the registered outputs line
  // up with the state they belong to.
  always_comb begin
    c1_d = ~(state_d == S_COIN);
    s1_d = ~((state_d == S_START) & ~sel_2p_d);
    s2_d = ~((state_d == S_START) & sel_2p_d);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      o_c1_n <= 1'b1;
      o_s1_n <= 1'b1;
      o_s2_n <= 1'b1;
    end else begin
      o_c1_n <= c1_d;
      o_s1_n <= s1_d;
      o_s2_n <= s2_d;
    end
  end

endmodule

// File: tb/tb_dkong_input_ctrl.sv
module tb_dkong_input_ctrl;

  // Output vector order: {u, d, l, r, j, s1, s2, c1}, all active-low.
  localparam logic [7:0] V_IDLE  = 8'hFF;
  localparam logic [7:0] V_COIN  = 8'hFE;
  localparam logic [7:0] V_S1    = 8'hFB;
  localparam logic [7:0] V_S2    = 8'hFD;
  localparam logic [7:0] V_UP    = 8'h7F;
  localparam logic [7:0] V_JUMP  = 8'hF7;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joy;
  logic        rotate;
  logic        o_u_n, o_d_n, o_l_n, o_r_n, o_j_n, o_s1_n, o_s2_n, o_c1_n;
  logic [7:0]  outs;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 clk_sys = ~clk_sys;

  dkong_input_ctrl #(
    .CNT_W(24),
    .COIN_CYCLES(4),
    .GAP_CYCLES(3),
    .START_CYCLES(5)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joy(joy),
    .rotate(rotate),
    .o_u_n(o_u_n),
    .o_d_n(o_d_n),
    .o_l_n(o_l_n),
    .o_r_n(o_r_n),
    .o_j_n(o_j_n),
    .o_s1_n(o_s1_n),
    .o_s2_n(o_s2_n),
    .o_c1_n(o_c1_n)
  );

  assign outs = {o_u_n, o_d_n, o_l_n, o_r_n, o_j_n, o_s1_n, o_s2_n, o_c1_n};

  task checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task pushExpect(input string tag, input logic [7:0] vec, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(vec);
      tag_q.push_back(tag);
    end
  endtask

  // One queue entry per following negedge.
  task drainScoreboard();
    logic [7:0] e;
    string      t;
    while (exp_q.size() > 0) begin
      @(negedge clk_sys);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checkOutput(t, outs, e);
    end
  endtask

  // Called at a negedge; the DUT samples on the next posedge.
  task applyStimulus(input logic [15:0] joy_v, input logic rotate_v);
    joy    = joy_v;
    rotate = rotate_v;
  endtask

  task sendKey(input logic [8:0] code, input logic pressed);
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  // Expected trace of a full sequence from the cycle after the trigger.
  task pushSequence(input string tag, input logic [7:0] start_vec, input int tail);
    pushExpect({tag, "_coin"}, V_COIN, 4);
    pushExpect({tag, "_gap"}, V_IDLE, 3);
    pushExpect({tag, "_start"}, start_vec, 5);
    pushExpect({tag, "_wait"}, V_IDLE, tail);
  endtask

  logic [15:0] dir_joy[6] = '{16'h0001, 16'h0004, 16'h0008, 16'h0001, 16'h0008, 16'h000F};
  logic        dir_rot[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0]  dir_exp[6] = '{8'hBF, 8'hDF, 8'hEF, 8'hEF, 8'h7F, 8'h0F};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    ps2_key = '0;
    joy     = 16'h0020;
    rotate  = 1'b0;

    // Reset held with start1 asserted
    @(negedge clk_sys);
    pushExpect("reset_hold", V_IDLE, 3);
    drainScoreboard();
    reset_n = 1'b1;
    pushExpect("held_after_reset", V_IDLE, 8);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("release_s1", V_IDLE, 2);
    drainScoreboard();

    // Fresh 1P press, exact phase timing
    applyStimulus(16'h0020, 1'b0);
    pushSequence("seq1p", V_S1, 3);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("seq1p_rel", V_IDLE, 2);
    drainScoreboard();

    // Both starts rise together -> 1P wins
    applyStimulus(16'h0060, 1'b0);
    pushSequence("both", V_S1, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("both_rel", V_IDLE, 2);
    drainScoreboard();

    // F2 via PS/2 only -> 2P (one extra cycle through the key register)
    sendKey(9'h006, 1'b1);
    pushExpect("f2_lat", V_IDLE, 1);
    pushSequence("f2", V_S2, 2);
    drainScoreboard();
    sendKey(9'h006, 1'b0);
    pushExpect("f2_rel", V_IDLE, 3);
    drainScoreboard();

    // E0-prefixed F1 code is not a start key
    sendKey(9'h105, 1'b1);
    pushExpect("ext_f1_ignored", V_IDLE, 12);
    drainScoreboard();
    sendKey(9'h105, 1'b0);
    pushExpect("ext_f1_rel", V_IDLE, 2);
    drainScoreboard();

    // Extended up arrow, rotate=0
    sendKey(9'h175, 1'b1);
    pushExpect("up_lat", V_IDLE, 1);
    pushExpect("up_press", V_UP, 3);
    drainScoreboard();
    sendKey(9'h175, 1'b0);
    pushExpect("up_hold", V_UP, 1);
    pushExpect("up_rel", V_IDLE, 2);
    drainScoreboard();

    // rotate=1: joystick left drives up
    applyStimulus(16'h0002, 1'b1);
    pushExpect("rot_left_to_up", V_UP, 3);
    drainScoreboard();
    sendKey(9'h075, 1'b1);
    pushExpect("rot_key_lat", V_UP, 1);
    pushExpect("rot_up_to_right", 8'h6F, 2);
    drainScoreboard();
    sendKey(9'h075, 1'b0);
    pushExpect("rot_key_hold", 8'h6F, 1);
    pushExpect("rot_key_rel", V_UP, 1);
    drainScoreboard();

    // Direction remap table
    for (int i = 0; i < 6; i++) begin
      applyStimulus(dir_joy[i], dir_rot[i]);
      pushExpect($sformatf("dir_tbl%0d", i), dir_exp[i], 2);
      drainScoreboard();
    end
    applyStimulus(16'h0000, 1'b0);
    pushExpect("dir_clear", V_IDLE, 2);
    drainScoreboard();

    // Jump sources
    applyStimulus(16'h0010, 1'b0);
    pushExpect("jump_joy", V_JUMP, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("jump_joy_rel", V_IDLE, 2);
    drainScoreboard();
    sendKey(9'h029, 1'b1);
    pushExpect("space_lat", V_IDLE, 1);
    pushExpect("space", V_JUMP, 2);
    drainScoreboard();
    sendKey(9'h014, 1'b1);
    pushExpect("space_ctrl", V_JUMP, 2);
    drainScoreboard();
    sendKey(9'h029, 1'b0);
    pushExpect("ctrl_only", V_JUMP, 2);
    drainScoreboard();
    sendKey(9'h014, 1'b0);
    pushExpect("ctrl_hold", V_JUMP, 1);
    pushExpect("jump_keys_rel", V_IDLE, 2);
    drainScoreboard();
    sendKey(9'h129, 1'b1);
    pushExpect("ext_space_ignored", V_IDLE, 3);
    drainScoreboard();
    sendKey(9'h129, 1'b0);

    // Start2 held through the whole sequence, then re-pressed
    applyStimulus(16'h0040, 1'b0);
    pushSequence("hold2p", V_S2, 4);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("hold2p_rel", V_IDLE, 2);
    drainScoreboard();
    applyStimulus(16'h0040, 1'b0);
    pushSequence("repress2p", V_S2, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("repress2p_rel", V_IDLE, 2);
    drainScoreboard();

    // A new edge during COIN is ignored and not queued
    applyStimulus(16'h0020, 1'b0);
    pushExpect("noq_coin_a", V_COIN, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("noq_coin_b", V_COIN, 1);
    drainScoreboard();
    applyStimulus(16'h0020, 1'b0);
    pushExpect("noq_coin_c", V_COIN, 1);
    pushExpect("noq_gap", V_IDLE, 3);
    pushExpect("noq_start", V_S1, 5);
    pushExpect("noq_wait", V_IDLE, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("noq_none", V_IDLE, 12);
    drainScoreboard();

    // Reset during COIN acts immediately
    applyStimulus(16'h0020, 1'b0);
    pushExpect("abort_coin", V_COIN, 2);
    drainScoreboard();
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_async", outs, V_IDLE);
    @(negedge clk_sys);
    reset_n = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    pushExpect("after_abort", V_IDLE, 4);
    drainScoreboard();
    applyStimulus(16'h0020, 1'b0);
    pushSequence("post_abort", V_S1, 2);
    drainScoreboard();
    applyStimulus(16'h0000, 1'b0);
    pushExpect("post_abort_rel", V_IDLE, 2);
    drainScoreboard();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
